iir_coeff_ctrl: RTL and testbench

IIR_COEFF_CTRL -- requirements
Module: iir_coeff_ctrl

---
 rtl/iir_ctrl_pkg.sv | 33 +++
 rtl/iir_coeff_bank.sv | 48 ++++
 rtl/iir_coeff_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_iir_coeff_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_ctrl_pkg.sv
// Shared definitions for the notch-filter coefficient update controller.
//   - default coefficient geometry (Q2.18, five taps: b0,b1,b2,a1,a2)
//   - filter index constants (1 MHz, 2 MHz, 2.4 MHz notches)
//   - controller state encoding
//   - identity coefficient set (b0 = 1.0, everything else 0)
package iir_ctrl_pkg;

  localparam int unsigned CoeffWidthDef = 20;
  localparam int unsigned CoeffDepthDef = 5;

  localparam int unsigned NumFilters = 3;
  localparam int unsigned Filt1MHz   = 0;
  localparam int unsigned Filt2MHz   = 1;
  localparam int unsigned Filt2p4MHz = 2;

  // 1.0 in Q2.18
  localparam logic [31:0] IdentityB0 = 32'h0004_0000;

  typedef enum logic [2:0] {
    StIdle,
    StDrain,
    StWrite,
    StVerify,
    StSettle,
    StDone
  } ctrl_state_e;

  // Reset value of coefficient idx: a pass-through biquad.
  function automatic logic [31:0] identity_coeff(input int unsigned idx);
    return (idx == 0) ? IdentityB0 : 32'h0;
  endfunction

endpackage

// File: rtl/iir_coeff_bank.sv
// Shadow register file for one notch filter plus its readback comparator.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (reset loads identity)
//   wr_en_i      write one shadow entry selected by wr_idx_i with wr_data_i
//   readback_i   coefficient set read back from the filter
//   shadow_o     current shadow contents (driven to the filter)
//   mismatch_o   readback differs from shadow
module iir_coeff_bank
  import iir_ctrl_pkg::*;
#(
  parameter int unsigned Width = CoeffWidthDef,
  parameter int unsigned Depth = CoeffDepthDef
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en_i,
  input  logic [2:0]                   wr_idx_i,
  input  logic [Width-1:0]             wr_data_i,
  input  logic [Depth-1:0][Width-1:0]  readback_i,
  output logic [Depth-1:0][Width-1:0]  shadow_o,
  output logic                         mismatch_o
);

  logic [Depth-1:0][Width-1:0] shadow_d, shadow_q;

  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (wr_en_i && (wr_idx_i == 3'(i))) begin
        shadow_d[i] = wr_data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        shadow_q[i] <= Width'(identity_coeff(i));
      end
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign shadow_o   = shadow_q;
  assign mismatch_o = (readback_i != shadow_q);

endmodule

// File: rtl/iir_coeff_ctrl.sv
// Coefficient update controller for three IIR notch filters.
// Software fills per-filter shadow registers (cfg_wr/cfg_sel/cfg_idx/cfg_data,
// answered by cfg_ack or cfg_err), then cfg_commit with cfg_mask starts an
// update: masked filters are bypassed, the chain is drained, coefficients are
// written in one cycle, read back and verified, and bypass is held while the
// filter state settles. done pulses at the end.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   valid_in                        IIR chain sample strobe (paces drain/settle)
//   cfg_*                           shadow write and commit interface
//   bypass_sw                       software bypass, ORed into bypass
//   ovf_in, unf_in, status_clr      filter flags and sticky clear
//   coeff_in_*                      shadow contents to each filter
//   coeff_out_*                     readback from each filter
//   coeff_wr_en, bypass             per-filter write enable and bypass
//   cfg_ack, cfg_err, busy, done    handshake / status
//   verr, ovf_sticky, unf_sticky    sticky status
module iir_coeff_ctrl
  import iir_ctrl_pkg::*;
#(
  parameter int unsigned COEFF_WIDTH    = CoeffWidthDef,
  parameter int unsigned COEFF_DEPTH    = CoeffDepthDef,
  parameter int unsigned DRAIN_SAMPLES  = 2,
  parameter int unsigned SETTLE_SAMPLES = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    valid_in,
  input  logic                                    cfg_wr,
  input  logic [1:0]                              cfg_sel,
  input  logic [2:0]                              cfg_idx,
  input  logic [COEFF_WIDTH-1:0]                  cfg_data,
  input  logic                                    cfg_commit,
  input  logic [2:0]                              cfg_mask,
  input  logic [2:0]                              bypass_sw,
  input  logic [2:0]                              ovf_in,
  input  logic [2:0]                              unf_in,
  input  logic                                    status_clr,
  output logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_in_1MHz,
  output logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_in_2MHz,
  output logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_in_2_4MHz,
  input  logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_out_1MHz,
  input  logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_out_2MHz,
  input  logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_out_2_4MHz,
  output logic [2:0]                              coeff_wr_en,
  output logic [2:0]                              bypass,
  output logic                                    cfg_ack,
  output logic                                    cfg_err,
  output logic                                    busy,
  output logic                                    done,
  output logic [2:0]                              verr,
  output logic [2:0]                              ovf_sticky,
  output logic [2:0]                              unf_sticky
);

  localparam int unsigned CntMax =
      (DRAIN_SAMPLES > SETTLE_SAMPLES) ? DRAIN_SAMPLES : SETTLE_SAMPLES;
  localparam int unsigned CntW = $clog2(CntMax + 2);
  localparam logic [CntW-1:0] DrainTgt  = CntW'(DRAIN_SAMPLES);
  localparam logic [CntW-1:0] SettleTgt = CntW'(SETTLE_SAMPLES);

  ctrl_state_e     state_d, state_q;
  logic [2:0]      mask_d, mask_q;
  logic [CntW-1:0] cnt_d, cnt_q, cnt_inc;
  logic [2:0]      verr_d, verr_q;
  logic [2:0]      ovf_d, ovf_q;
  logic [2:0]      unf_d, unf_q;
  logic            ack_d, ack_q;
  logic            err_d, err_q;

  logic [2:0]      bank_wr;
  logic [2:0]      mismatch;
  logic [2:0]      ctrl_byp;
  logic            wr_ok;

  logic [2:0][COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] shadow;
  logic [2:0][COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] readback;

  // Shadow banks

  assign readback[Filt1MHz]   = coeff_out_1MHz;
  assign readback[Filt2MHz]   = coeff_out_2MHz;
  assign readback[Filt2p4MHz] = coeff_out_2_4MHz;

  assign coeff_in_1MHz   = shadow[Filt1MHz];
  assign coeff_in_2MHz   = shadow[Filt2MHz];
  assign coeff_in_2_4MHz = shadow[Filt2p4MHz];

  // Shadows are frozen while an update is in flight so VERIFY compares what was written.
  assign busy  = (state_q != StIdle);
  assign wr_ok = cfg_wr && !busy && (cfg_sel < 2'd3) && (32'(cfg_idx) < COEFF_DEPTH);

  always_comb begin
    bank_wr = '0;
    for (int unsigned f = 0; f < NumFilters; f++) begin
      bank_wr[f] = wr_ok && (cfg_sel == 2'(f));
    end
  end

  for (genvar f = 0; f < NumFilters; f++) begin : g_bank
    iir_coeff_bank #(
      .Width (COEFF_WIDTH),
      .Depth (COEFF_DEPTH)
    ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en_i    (bank_wr[f]),
      .wr_idx_i   (cfg_idx),
      .wr_data_i  (cfg_data),
      .readback_i (readback[f]),
      .shadow_o   (shadow[f]),
      .mismatch_o (mismatch[f])
    );
  end

  // Update sequencer

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (cfg_commit) begin
          cnt_d = '0;
          if (cfg_mask != 3'b000) begin
            mask_d  = cfg_mask;
            state_d = StDrain;
          end else begin
            mask_d  = '0;
            state_d = StDone;
          end
        end
      end
      StDrain: begin
        // The strobe that makes the count hit the target ends the phase this cycle.
        if (cnt_q == DrainTgt || (valid_in && cnt_inc == DrainTgt)) begin
          state_d = StWrite;
          cnt_d   = '0;
        end else if (valid_in) begin
          cnt_d = cnt_inc;
        end
      end
      StWrite: begin
        state_d = StVerify;
      end
      StVerify: begin
        state_d = StSettle;
        cnt_d   = '0;
      end
      StSettle: begin
        if (cnt_q == SettleTgt || (valid_in && cnt_inc == SettleTgt)) begin
          state_d = StDone;
          cnt_d   = '0;
        end else if (valid_in) begin
          cnt_d = cnt_inc;
        end
      end
      StDone: begin
        state_d = StIdle;
        mask_d  = '0;
      end
      default: begin
        state_d = StIdle;
        mask_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode from registered state only, so reset clears them asynchronously.
  always_comb begin
    ctrl_byp = '0;
    if (state_q == StDrain || state_q == StWrite || state_q == StVerify ||
        state_q == StSettle) begin
      ctrl_byp = mask_q;
    end
  end

  assign bypass      = bypass_sw | ctrl_byp;
  assign coeff_wr_en = (state_q == StWrite) ? mask_q : 3'b000;
  assign done        = (state_q == StDone);

  // Sticky status: a set on the same cycle as status_clr wins.
  always_comb begin
    verr_d = status_clr ? 3'b000 : verr_q;
    if (state_q == StVerify) begin
      verr_d = verr_d | (mask_q & mismatch);
    end
    ovf_d = (status_clr ? 3'b000 : ovf_q) | (ovf_in & ~bypass);
    unf_d = (status_clr ? 3'b000 : unf_q) | (unf_in & ~bypass);
    ack_d = wr_ok;
    err_d = cfg_wr && !wr_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mask_q  <= '0;
      cnt_q   <= '0;
      verr_q  <= '0;
      ovf_q   <= '0;
      unf_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      verr_q  <= verr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign verr       = verr_q;
  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;
  assign cfg_ack    = ack_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Self-checking bench for iir_coeff_ctrl: random shadow writes and sticky
// traffic checked against a reference model, plus commit sequences whose
// expected timing is derived from the drain/settle strobe counts.
module tb_iir_coeff_ctrl;

  localparam int W    = 20;
  localparam int D    = 5;
  localparam int DR   = 2;
  localparam int ST   = 16;
  localparam int MaxR = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0, cfg_wr = 1'b0, cfg_commit = 1'b0, status_clr = 1'b0;
  logic [1:0] cfg_sel = '0;
  logic [2:0] cfg_idx = '0, cfg_mask = '0, bypass_sw = '0, ovf_in = '0, unf_in = '0;
  logic [W-1:0] cfg_data = '0;
  logic [D-1:0][W-1:0] coeff_in_1MHz, coeff_in_2MHz, coeff_in_2_4MHz;
  logic [D-1:0][W-1:0] coeff_out_1MHz, coeff_out_2MHz, coeff_out_2_4MHz;
  logic [2:0] coeff_wr_en, bypass, verr, ovf_sticky, unf_sticky;
  logic cfg_ack, cfg_err, busy, done;
  logic corrupt = 1'b0;

  iir_coeff_ctrl #(
    .COEFF_WIDTH    (W),
    .COEFF_DEPTH    (D),
    .DRAIN_SAMPLES  (DR),
    .SETTLE_SAMPLES (ST)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_in         (valid_in),
    .cfg_wr           (cfg_wr),
    .cfg_sel          (cfg_sel),
    .cfg_idx          (cfg_idx),
    .cfg_data         (cfg_data),
    .cfg_commit       (cfg_commit),
    .cfg_mask         (cfg_mask),
    .bypass_sw        (bypass_sw),
    .ovf_in           (ovf_in),
    .unf_in           (unf_in),
    .status_clr       (status_clr),
    .coeff_in_1MHz    (coeff_in_1MHz),
    .coeff_in_2MHz    (coeff_in_2MHz),
    .coeff_in_2_4MHz  (coeff_in_2_4MHz),
    .coeff_out_1MHz   (coeff_out_1MHz),
    .coeff_out_2MHz   (coeff_out_2MHz),
    .coeff_out_2_4MHz (coeff_out_2_4MHz),
    .coeff_wr_en      (coeff_wr_en),
    .bypass           (bypass),
    .cfg_ack          (cfg_ack),
    .cfg_err          (cfg_err),
    .busy             (busy),
    .done             (done),
    .verr             (verr),
    .ovf_sticky       (ovf_sticky),
    .unf_sticky       (unf_sticky)
  );

  always #5 clk = ~clk;

  // Filter model: latches the shadow on write enable; optional bit flip on readback.
  logic [D-1:0][W-1:0] fmem [3];
  always @(posedge clk) begin
    if (coeff_wr_en[0]) fmem[0] <= coeff_in_1MHz;
    if (coeff_wr_en[1]) fmem[1] <= coeff_in_2MHz;
    if (coeff_wr_en[2]) fmem[2] <= coeff_in_2_4MHz;
  end
  assign coeff_out_1MHz   = corrupt ? (fmem[0] ^ (D*W)'(1)) : fmem[0];
  assign coeff_out_2MHz   = fmem[1];
  assign coeff_out_2_4MHz = fmem[2];

  // Reference model state
  logic [W-1:0] m_shadow [3][D];
  logic [2:0]   m_verr, m_ovf, m_unf;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < D; i++)
        m_shadow[f][i] = (i == 0) ? W'(20'h40000) : '0;
    m_verr = '0;
    m_ovf  = '0;
    m_unf  = '0;
  endtask

  function automatic logic [D*W-1:0] pack(input int f);
    logic [D*W-1:0] v;
    for (int i = 0; i < D; i++) v[i*W +: W] = m_shadow[f][i];
    return v;
  endfunction

  task automatic check_shadows();
    check_eq("shadow_1MHz", coeff_in_1MHz, pack(0));
    check_eq("shadow_2MHz", coeff_in_2MHz, pack(1));
    check_eq("shadow_2_4MHz", coeff_in_2_4MHz, pack(2));
  endtask

  task automatic drive_idle();
    valid_in = 0; cfg_wr = 0; cfg_commit = 0; cfg_mask = 0; status_clr = 0;
    bypass_sw = 0; ovf_in = 0; unf_in = 0;
  endtask

  // Random shadow writes, software bypass and sticky traffic while idle.
  task automatic run_idle_random(input int n);
    logic exp_ack = 0, exp_err = 0;
    logic [2:0] m_bsw = bypass_sw;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_eq("idle_busy", busy, 1'b0);
      check_eq("idle_bypass", bypass, m_bsw);
      check_eq("cfg_ack", cfg_ack, exp_ack);
      check_eq("cfg_err", cfg_err, exp_err);
      check_eq("ovf_sticky", ovf_sticky, m_ovf);
      check_eq("unf_sticky", unf_sticky, m_unf);
      check_eq("verr_idle", verr, m_verr);
      check_shadows();
      cfg_wr     = 1'($urandom_range(0, 1));
      cfg_sel    = 2'($urandom_range(0, 3));
      cfg_idx    = 3'($urandom_range(0, 7));
      cfg_data   = W'($urandom);
      status_clr = ($urandom_range(0, 7) == 0);
      ovf_in     = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      unf_in     = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      bypass_sw  = 3'($urandom);
      m_bsw      = bypass_sw;
      exp_ack    = cfg_wr && cfg_sel < 3 && cfg_idx < D;
      exp_err    = cfg_wr && !exp_ack;
      if (exp_ack) m_shadow[cfg_sel][cfg_idx] = cfg_data;
      m_ovf  = (status_clr ? 3'b000 : m_ovf) | (ovf_in & ~bypass_sw);
      m_unf  = (status_clr ? 3'b000 : m_unf) | (unf_in & ~bypass_sw);
      if (status_clr) m_verr = '0;
    end
  endtask

  // One commit. vmode: 0 valid always, 1 one strobe in six, 2 random (~75%).
  task automatic run_commit(input logic [2:0] mask, input int vmode, input logic corrupt_1m,
                            input logic [2:0] ovf_v, input bit poke_busy);
    bit v [MaxR+1];
    int wr_r, done_r, cnt;
    logic [2:0] exp_byp;
    for (int r = 0; r <= MaxR; r++) begin
      case (vmode)
        0:       v[r] = 1;
        1:       v[r] = (r % 6 == 0);
        default: v[r] = (r >= 200) || ($urandom_range(0, 3) != 0);
      endcase
    end
    // Expected schedule from strobe counting: drain counts strobes from the cycle after
    // the commit; settle starts two cycles after the write cycle.
    wr_r = -1;
    done_r = -1;
    if (mask == 0) begin
      done_r = 1;
    end else begin
      cnt = 0;
      for (int r = 1; r <= MaxR && wr_r < 0; r++) begin
        cnt += int'(v[r]);
        if (cnt == DR) wr_r = r + 1;
      end
      cnt = 0;
      for (int r = wr_r + 2; r <= MaxR && done_r < 0; r++) begin
        cnt += int'(v[r]);
        if (cnt == ST) done_r = r + 1;
      end
    end
    if (done_r < 0) begin
      check_eq("schedule_in_budget", 0, 1);
      done_r = 1;
    end
    corrupt = corrupt_1m;
    for (int r = 0; r <= done_r + 1; r++) begin
      @(negedge clk);
      exp_byp = (r >= 1 && r < done_r) ? mask : 3'b000;
      if (r >= 1) begin
        check_eq("busy", busy, (r <= done_r));
        check_eq("bypass", bypass, exp_byp);
        check_eq("coeff_wr_en", coeff_wr_en, (r == wr_r) ? mask : 3'b000);
        check_eq("done", done, (r == done_r));
        check_eq("ovf_sticky_upd", ovf_sticky, m_ovf);
      end
      if (poke_busy && r == 3) begin
        check_eq("busy_wr_err", cfg_err, 1'b1);
        check_eq("busy_wr_ack", cfg_ack, 1'b0);
      end
      drive_idle();
      valid_in   = v[r];
      cfg_commit = (r == 0) || (poke_busy && r == 2);
      cfg_mask   = (r == 0) ? mask : 3'b111;
      cfg_wr     = poke_busy && r == 2;
      cfg_sel    = 2'd0;
      cfg_idx    = 3'd0;
      cfg_data   = W'($urandom);
      ovf_in     = (r >= 1) ? ovf_v : 3'b000;
      m_ovf      = m_ovf | (ovf_in & ~exp_byp);
    end
    m_verr = m_verr | (mask & {2'b00, corrupt_1m});
    check_eq("verr", verr, m_verr);
    check_eq("unf_sticky_upd", unf_sticky, m_unf);
    check_shadows();
    drive_idle();
  endtask

  task automatic reset_mid_settle();
    for (int r = 0; r <= 9; r++) begin
      @(negedge clk);
      drive_idle();
      valid_in   = 1;
      cfg_commit = (r == 0);
      cfg_mask   = 3'b111;
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_bypass", bypass, 3'b000);
    check_eq("rst_wr_en", coeff_wr_en, 3'b000);
    check_shadows();
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      check_eq("post_rst_wr_en", coeff_wr_en, 3'b000);
      check_eq("post_rst_busy", busy, 1'b0);
      check_eq("post_rst_done", done, 1'b0);
    end
    check_eq("post_rst_verr", verr, m_verr);
    drive_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    drive_idle();
    repeat (3) @(negedge clk);
    rst_n = 1;

    // Reset state
    @(negedge clk);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_bypass", bypass, 3'b000);
    check_eq("reset_wr_en", coeff_wr_en, 3'b000);
    check_eq("reset_done", done, 1'b0);
    check_eq("reset_ack", cfg_ack, 1'b0);
    check_eq("reset_verr", verr, 3'b000);
    check_eq("reset_ovf", ovf_sticky, 3'b000);
    check_shadows();

    // Directed write to 2MHz idx3, then an invalid select
    cfg_wr = 1; cfg_sel = 2'd1; cfg_idx = 3'd3; cfg_data = W'(20'hABCDE);
    m_shadow[1][3] = W'(20'hABCDE);
    @(negedge clk);
    check_eq("ack_valid_wr", cfg_ack, 1'b1);
    check_eq("err_valid_wr", cfg_err, 1'b0);
    check_eq("coeff_2MHz_3", coeff_in_2MHz[3], 20'hABCDE);
    cfg_sel = 2'd3; cfg_idx = 3'd0; cfg_data = W'(20'h12345);
    @(negedge clk);
    check_eq("err_bad_sel", cfg_err, 1'b1);
    check_eq("ack_bad_sel", cfg_ack, 1'b0);
    check_shadows();
    drive_idle();

    run_idle_random(60);
    run_commit(3'b101, 0, 1'b0, 3'b000, 1'b1);
    run_commit(3'b001, 0, 1'b1, 3'b000, 1'b0);
    @(negedge clk);
    corrupt = 0;
    status_clr = 1;
    m_verr = '0;
    @(negedge clk);
    status_clr = 0;
    check_eq("verr_cleared", verr, 3'b000);
    run_commit(3'b111, 1, 1'b0, 3'b000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      run_idle_random(10);
      run_commit(3'($urandom_range(1, 7)), 2, 1'b0, 3'b000, 1'b0);
    end
    run_commit(3'b100, 0, 1'b0, 3'b100, 1'b0);
    run_commit(3'b000, 0, 1'b0, 3'b000, 1'b0);
    run_idle_random(30);
    reset_mid_settle();
    run_idle_random(15);
    run_commit(3'b010, 0, 1'b0, 3'b000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
